result_fifo: RTL and testbench
==============================

RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 Parameter WIDTH, default 32: product word width, matching the multiplier's 32-bit P output.
REQ-002 Parameter DEPTH, default 4: number of entries; a power of two, minimum 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous clear of all stored entries.
REQ-006 in_valid  input  1  upstream multiplier presents a product (driven by its dst_valid).
REQ-007 in_data  input  WIDTH  product from the multiplier datapath P.
REQ-008 in_ready  output  1  FIFO can accept a word this cycle (drives the multiplier's dst_ready).
REQ-009 out_valid  output  1  head entry available to the consumer.
REQ-010 out_data  output  WIDTH  head entry value.
REQ-011 out_ready  input  1  consumer accepts the head entry.
REQ-012 count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.

Function
REQ-015 A push SHALL occur on a rising edge when in_valid && in_ready && !flush.
REQ-016 A pop SHALL occur on a rising edge when out_valid && out_ready && !flush.
REQ-017 in_ready SHALL equal !full, decoded from registered state only; there is no combinational path from out_ready to in_ready.
REQ-018 out_valid SHALL equal !empty.
REQ-019 out_data SHALL equal the entry at the read pointer when out_valid=1, and 0 when empty.
REQ-020 Latency: a word pushed at edge N SHALL be visible on out_data/out_valid immediately after edge N (one cycle in to out).
REQ-021 Order SHALL be strict FIFO, with no loss or duplication.
REQ-022 Write and read pointers are each $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-023 Push and pop on the same edge SHALL leave count unchanged and advance both pointers.
REQ-024 On empty, no pop is possible; a push SHALL make count 1.
REQ-025 On full, push is blocked; a pop SHALL free one entry, and in_ready SHALL rise on the following cycle.
REQ-026 An in_valid held high while in_ready=0 SHALL neither alter state nor lose data; the upstream holds in_data stable.
REQ-027 flush=1 at an edge SHALL zero the pointers and count, and SHALL override any push or pop on the same edge.
REQ-028 Entry memory is not cleared by flush or reset; only the pointers and count are cleared.
REQ-029 full, empty and count SHALL stay mutually consistent every cycle.

Reset
REQ-030 While reset=1, the block SHALL immediately force: pointers=0, count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries with no partial pop.
REQ-032 The first push SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-033 The shared package mul_pkg SHALL hold the WIDTH/DEPTH defaults and the pointer/count width constants used by the multiplier and this FIFO.
REQ-034 The storage array SHALL be a sub-module, result_fifo_mem (write port plus combinational read port, no reset); pointer and count control stay in result_fifo.

Verification
REQ-035 Reset, then push 0x0000_0006 (3x2) -> next cycle out_valid=1, out_data=0x0000_0006, count=1, empty=0.
REQ-036 Push 0xFFFF_FFFA, 0x0000_0010, 0x3FFF_0001, 0x8000_0000 with out_ready=0 -> full=1, in_ready=0, count=4; a fifth in_valid is held off; drain returns the four words in order.
REQ-037 With the FIFO at count=2, push and pop simultaneously for 10 cycles -> count stays 2, the pointers wrap, and the output sequence matches the input sequence.
REQ-038 When full, pop one (out_ready=1) -> the same edge gives count=3; in_ready=1 the next cycle; the following push makes count=4 again.
REQ-039 With count=3, assert flush together with in_valid=1 and out_ready=1 -> the next cycle count=0, empty=1, out_data=0, and nothing was popped or pushed.
REQ-040 Assert reset asynchronously mid-cycle with count=2 -> outputs go to their reset values before the next edge; after release, a push of 0x1234_5678 is read back correctly.

Source files
------------

// File: rtl/mul_pkg.sv
// Defaults and width helpers shared by the multiplier datapath and its result FIFO.
package mul_pkg;

  localparam int unsigned MUL_WIDTH  = 32;
  localparam int unsigned FIFO_DEPTH = 4;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned MUL_PTR_W = ptr_width(FIFO_DEPTH);
  localparam int unsigned MUL_CNT_W = MUL_PTR_W + 1;

endpackage

// File: rtl/result_fifo_if.sv
// Producer/consumer handshake and status bundle of the result FIFO.
interface result_fifo_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEPTH
);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, full, empty
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, full, empty
  );
endinterface

// File: rtl/result_fifo_mem.sv
// Entry storage: one synchronous write port, one combinational read port, no reset.
module result_fifo_mem
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/result_fifo.sv
// Result FIFO behind the multiplier: pointer/count control around result_fifo_mem.
module result_fifo
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  result_fifo_if.slave  bus
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             full_c, empty_c, push_c, pop_c;
  logic [WIDTH-1:0] rdata;

  // Status is decoded only from registered count, so in_ready never sees out_ready.
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign push_c  = bus.in_valid && !full_c && !bus.flush;
  assign pop_c   = !empty_c && bus.out_ready && !bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  result_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_c),
    .waddr (wr_ptr_q),
    .wdata (bus.in_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign bus.in_ready  = !full_c;
  assign bus.out_valid = !empty_c;
  assign bus.out_data  = empty_c ? '0 : rdata;
  assign bus.count     = count_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;

endmodule

// File: tb/tb_result_fifo.sv
// Self-checking bench for result_fifo: vector table plus multi-cycle corner sequences.
module tb_result_fifo;
  import mul_pkg::*;

  typedef struct {
    logic                 flush;
    logic                 in_valid;
    logic [31:0]          in_data;
    logic                 out_ready;
    logic [MUL_CNT_W-1:0] cnt;
    logic                 ov;
    logic [31:0]          od;
    logic                 full;
    logic                 empty;
    logic                 ir;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];
  logic [31:0] sq[$];

  result_fifo_if #(.WIDTH(32), .DEPTH(4)) bus ();

  result_fifo #(.WIDTH(32), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [MUL_CNT_W-1:0] c, input logic ov,
                              input logic [31:0] od, input logic fu, input logic em, input logic ir);
    check({tag, ".count"},     32'(bus.count),     32'(c));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, ".out_data"},  bus.out_data,       od);
    check({tag, ".full"},      32'(bus.full),      32'(fu));
    check({tag, ".empty"},     32'(bus.empty),     32'(em));
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(ir));
  endtask

  task automatic add(input logic f, input logic iv, input logic [31:0] d, input logic ordy,
                     input logic [MUL_CNT_W-1:0] c, input logic ov, input logic [31:0] od,
                     input logic fu, input logic em, input logic ir);
    vec_t v;
    v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.cnt = c; v.ov = ov; v.od = od; v.full = fu; v.empty = em; v.ir = ir;
    vq.push_back(v);
  endtask

  // Drive inputs, take one edge, settle just after it.
  task automatic step(input logic f, input logic iv, input logic [31:0] d, input logic ordy);
    bus.flush = f; bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #2;
    check_status("reset", 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    #10 reset = 1'b0;

    // flush in_valid in_data out_ready | count ov out_data full empty in_ready
    add(1'b0, 1'b1, 32'h0000_0006, 1'b0, 3'd1, 1'b1, 32'h0000_0006, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 32'h0,         1'b1, 3'd0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 32'hFFFF_FFFA, 1'b0, 3'd1, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h0000_0010, 1'b0, 3'd2, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h3FFF_0001, 1'b0, 3'd3, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h8000_0000, 1'b0, 3'd4, 1'b1, 32'hFFFF_FFFA, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3'd4, 1'b1, 32'hFFFF_FFFA, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3'd4, 1'b1, 32'hFFFF_FFFA, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 3'd3, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3'd4, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h0,         1'b1, 3'd3, 1'b1, 32'h3FFF_0001, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 32'h0,         1'b1, 3'd2, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 32'h0,         1'b1, 3'd1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 32'h0,         1'b1, 3'd0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 32'h0000_0011, 1'b0, 3'd1, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h0000_0022, 1'b0, 3'd2, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h0000_0033, 1'b0, 3'd3, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 32'h0000_0044, 1'b1, 3'd0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 32'h0,         1'b1, 3'd0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 32'h0000_0055, 1'b0, 3'd1, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 32'h0,         1'b1, 3'd0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1);

    foreach (vq[i]) begin
      step(vq[i].flush, vq[i].in_valid, vq[i].in_data, vq[i].out_ready);
      check_status($sformatf("vec%0d", i), vq[i].cnt, vq[i].ov, vq[i].od,
                   vq[i].full, vq[i].empty, vq[i].ir);
    end

    // Steady push+pop at count=2: pointers wrap, order preserved.
    step(1'b0, 1'b1, 32'hA000_0000, 1'b0); sq.push_back(32'hA000_0000);
    step(1'b0, 1'b1, 32'hA000_0001, 1'b0); sq.push_back(32'hA000_0001);
    check("stream.fill_count", 32'(bus.count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stream%0d.popped", i), bus.out_data, sq[0]);
      step(1'b0, 1'b1, 32'hB000_0000 + 32'(i), 1'b1);
      sq.push_back(32'hB000_0000 + 32'(i));
      void'(sq.pop_front());
      check($sformatf("stream%0d.count", i), 32'(bus.count), 32'd2);
      check($sformatf("stream%0d.head", i), bus.out_data, sq[0]);
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("drain%0d.data", i), bus.out_data, sq[0]);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      void'(sq.pop_front());
    end
    check_status("drained", 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle with two entries stored.
    step(1'b0, 1'b1, 32'hC000_0001, 1'b0);
    step(1'b0, 1'b1, 32'hC000_0002, 1'b0);
    check("prereset.count", 32'(bus.count), 32'd2);
    bus.in_valid = 1'b0;
    #3 reset = 1'b1;
    #1 check_status("async_reset", 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1 check_status("held_reset", 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    #2 reset = 1'b0;
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0);
    check_status("post_reset_push", 3'd1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_status("post_reset_pop", 3'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
